// File: rtl/ultrasonic_filter_if.sv
// Echo-result bus between the ultrasonic driver side (master) and the range filter (slave).
// Carries the trigger/result inputs and all filtered outputs, including the optional BCD copy.
interface ultrasonic_filter_if;
    logic        trig;
    logic [15:0] result;
    logic [15:0] dist_avg;
    logic        valid;
    logic        sample_stb;
    logic        near;
    logic        lost;
    logic [19:0] bcd;
    logic        bcd_valid;

    modport master (
        output trig, result,
        input  dist_avg, valid, sample_stb, near, lost, bcd, bcd_valid
    );

    modport slave (
        input  trig, result,
        output dist_avg, valid, sample_stb, near, lost, bcd, bcd_valid
    );
endinterface

// File: rtl/ultrasonic_filter.sv
// Range filter: moving average, near alarm with hysteresis, echo-loss flag; ULTRASONIC_BCD_EN adds a BCD copy.
// Latency: result captured on the trig rise edge, outputs and sample_stb visible 2 edges later (BCD +17 cycles).
// Backpressure: none; accepts one sample per trig rise, at most one per cycle, never stalls.
module ultrasonic_filter #(
    parameter int LOG2_WIN   = 3,
    parameter int MAX_DIST   = 4000,
    parameter int NEAR_ON    = 300,
    parameter int NEAR_OFF   = 350,
    parameter int MISS_LIMIT = 4
) (
    input  logic               clk0,
    input  logic               rst,
    ultrasonic_filter_if.slave bus
);
    localparam int WIN    = 1 << LOG2_WIN;
    localparam int SUM_W  = 16 + LOG2_WIN;
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam logic [15:0]       MAX_D    = 16'(MAX_DIST);
    localparam logic [15:0]       ON_T     = 16'(NEAR_ON);
    localparam logic [15:0]       OFF_T    = 16'(NEAR_OFF);
    localparam logic [LOG2_WIN:0] FULL     = (LOG2_WIN + 1)'(WIN);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);

    logic                trig_q, trig_d;
    logic                cap_q, cap_d;
    logic [15:0]         sample_q, sample_d;
    logic                acc_q, acc_d;
    logic [15:0]         buf_q [WIN];
    logic [15:0]         buf_d [WIN];
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [LOG2_WIN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_WIN:0]   fill_q, fill_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic                lost_q, lost_d;
    logic [15:0]         dist_avg_q, dist_avg_d;
    logic                valid_q, valid_d;
    logic                stb_q, stb_d;
    logic                near_q, near_d;
    logic                rise, accept;
    logic [15:0]         avg_new;

    always_comb begin
        trig_d   = bus.trig;
        rise     = bus.trig & ~trig_q;
        cap_d    = rise;
        sample_d = rise ? bus.result : sample_q;
        acc_d    = cap_q;
        accept   = (sample_q != '0) && (sample_q <= MAX_D);

        buf_d    = buf_q;
        sum_d    = sum_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        miss_d   = miss_q;
        lost_d   = lost_q;
        if (cap_q) begin
            if (accept) begin
                sum_d            = sum_q + SUM_W'(sample_q) - SUM_W'(buf_q[wr_ptr_q]);
                buf_d[wr_ptr_q]  = sample_q;
                wr_ptr_d         = wr_ptr_q + 1'b1;
                fill_d           = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
                miss_d           = '0;
                lost_d           = 1'b0;
            end else begin
                miss_d = (miss_q == MISS_MAX) ? miss_q : miss_q + 1'b1;
                // Echo considered gone: drop the stale window so the average restarts cleanly.
                if (miss_d == MISS_MAX) begin
                    for (int i = 0; i < WIN; i++) buf_d[i] = '0;
                    sum_d    = '0;
                    wr_ptr_d = '0;
                    fill_d   = '0;
                    lost_d   = 1'b1;
                end
            end
        end

        avg_new    = sum_q[LOG2_WIN +: 16];
        dist_avg_d = dist_avg_q;
        valid_d    = valid_q;
        near_d     = near_q;
        stb_d      = acc_q;
        if (acc_q) begin
            dist_avg_d = avg_new;
            valid_d    = (fill_q == FULL);
            if (!valid_d)              near_d = 1'b0;
            else if (avg_new < ON_T)   near_d = 1'b1;
            else if (avg_new > OFF_T)  near_d = 1'b0;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            trig_q     <= 1'b0;
            cap_q      <= 1'b0;
            sample_q   <= '0;
            acc_q      <= 1'b0;
            for (int i = 0; i < WIN; i++) buf_q[i] <= '0;
            sum_q      <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            miss_q     <= '0;
            lost_q     <= 1'b0;
            dist_avg_q <= '0;
            valid_q    <= 1'b0;
            stb_q      <= 1'b0;
            near_q     <= 1'b0;
        end else begin
            trig_q     <= trig_d;
            cap_q      <= cap_d;
            sample_q   <= sample_d;
            acc_q      <= acc_d;
            buf_q      <= buf_d;
            sum_q      <= sum_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            miss_q     <= miss_d;
            lost_q     <= lost_d;
            dist_avg_q <= dist_avg_d;
            valid_q    <= valid_d;
            stb_q      <= stb_d;
            near_q     <= near_d;
        end
    end

    assign bus.dist_avg   = dist_avg_q;
    assign bus.valid      = valid_q;
    assign bus.sample_stb = stb_q;
    assign bus.near       = near_q;
    assign bus.lost       = lost_q;

`ifdef ULTRASONIC_BCD_EN
    logic [15:0] bin_q, bin_d;
    logic [19:0] dd_q, dd_d;
    logic [19:0] dd_adj;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [19:0] bcd_q, bcd_d;
    logic        bcd_valid_q, bcd_valid_d;

    // Double-dabble: add 3 to any digit >= 5, then shift one binary bit in per cycle.
    always_comb begin
        dd_adj = dd_q;
        for (int i = 0; i < 5; i++) begin
            if (dd_q[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = dd_q[4*i +: 4] + 4'd3;
        end
        bin_d       = bin_q;
        dd_d        = dd_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        bcd_d       = bcd_q;
        bcd_valid_d = bcd_valid_q;
        if (stb_q) begin
            bin_d       = dist_avg_q;
            dd_d        = '0;
            cnt_d       = 5'd16;
            busy_d      = 1'b1;
            bcd_valid_d = 1'b0;
        end else if (busy_q) begin
            {dd_d, bin_d} = {dd_adj[18:0], bin_q, 1'b0};
            cnt_d         = cnt_q - 1'b1;
            if (cnt_q == 5'd1) begin
                busy_d      = 1'b0;
                bcd_d       = dd_d;
                bcd_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            bin_q       <= '0;
            dd_q        <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
        end else begin
            bin_q       <= bin_d;
            dd_q        <= dd_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign bus.bcd       = bcd_q;
    assign bus.bcd_valid = bcd_valid_q;
`else
    assign bus.bcd       = '0;
    assign bus.bcd_valid = 1'b0;
`endif
endmodule

// File: doc/ultrasonic_filter.md
Name: ultrasonic_filter

Overview:
- Downstream consumer of the ultrasonic driver's 16-bit echo-width result.
- Samples the result once per measurement cycle and rejects out-of-range readings.
- Keeps a 2^LOG2_WIN-deep moving average and raises a near-obstacle alarm with hysteresis.
- Flags loss of echo; optionally emits a BCD copy of the average for the seven-segment display stage.

Parameters:
LOG2_WIN, 3, log2 of averaging window depth (window = 8 samples)
MAX_DIST, 4000, largest accepted result; 0 and values above MAX_DIST are rejected
NEAR_ON, 300, near asserts when average < NEAR_ON
NEAR_OFF, 350, near deasserts when average > NEAR_OFF (must exceed NEAR_ON)
MISS_LIMIT, 4, consecutive rejected measurements that declare lost

Ports:
clk0  input  1  system clock; same clock that generates trig
rst  input  1  synchronous, active-high reset
trig  input  1  trigger pulse from the driver; a rising edge marks the previous result as final
result  input  16  echo high-time count from the driver
dist_avg  output  16  windowed average, sum >> LOG2_WIN
valid  output  1  window full since last flush
sample_stb  output  1  one-cycle pulse each time dist_avg/valid/near update
near  output  1  obstacle alarm with hysteresis
lost  output  1  MISS_LIMIT consecutive rejects seen
bcd  output  20  5-digit BCD of dist_avg (optional feature)
bcd_valid  output  1  bcd holds conversion of current dist_avg (optional feature)

Behaviour:
- Reset: all outputs, sample buffer, sum, write pointer, fill count, miss count and pipeline flags cleared to 0. Reset mid-pipeline discards the in-flight sample; no sample_stb follows.
- No synchronizer on trig, because it is in the same clock domain. Edge detect: rise = trig & ~trig_q. Trig held high yields exactly one sample.
- E0 (edge where rise=1): latch result into sample_q and set cap flag.
- E1: evaluate sample_q.
  - Accept if 1 <= sample_q <= MAX_DIST. Then:
    - sum <= sum + sample_q - buf[wr_ptr]; buf[wr_ptr] <= sample_q; wr_ptr wraps modulo 2^LOG2_WIN.
    - Increment fill count, saturating at 2^LOG2_WIN.
    - Clear miss count; clear lost.
  - Reject otherwise. Then:
    - Increment miss count, saturating at MISS_LIMIT.
    - When the count reaches MISS_LIMIT: set lost, and flush buffer, sum, wr_ptr and fill count to 0.
- sum width is 16+LOG2_WIN bits, so no overflow is possible.
- E2: dist_avg <= new sum >> LOG2_WIN (truncating); valid <= (fill == 2^LOG2_WIN); pulse sample_stb. The pulse fires on accept and reject alike.
- near is updated at E2 from the new average, only while the new valid is 1:
  - set if avg < NEAR_ON;
  - clear if avg > NEAR_OFF;
  - otherwise hold.
  - Forced 0 when valid is 0 or on flush.
- Latency: result captured at the rise edge, outputs visible 2 edges later.
- A new rise arriving during E1/E2 is still captured; the pipeline is fully pipelined, one sample per cycle max.
- Fill count is not reset by isolated rejects, only by flush.

Optional Feature:
ULTRASONIC_BCD_EN
- Defined: a sequential double-dabble converter starts on every sample_stb and converts dist_avg in 17 cycles (1 load + 16 shift/add-3).
  - bcd_valid drops at start and rises with the bcd register update on completion.
  - A new sample_stb during conversion restarts it with the new value.
  - Reset clears bcd and bcd_valid.
- Undefined: no converter logic; bcd and bcd_valid are tied to 0.

Test Plan:
1. Assert rst 3 cycles, toggle trig -> all outputs 0 throughout; first sample_stb exactly 2 edges after first rise edge after release.
2. 8 trig rises with result=1000 -> valid=0 on stbs 1-7, valid=1 and dist_avg=1000 on stb 8; near=0; with macro, bcd=20'h01000 and bcd_valid 17 cycles after stb.
3. After test 2, 8 samples of 200 -> dist_avg 900,800,...,300,200; near rises only at 200. Then samples of 400 -> 225,...,350,375; near clears only at 375.
4. Full window, then results 0,5000,0,4001 -> lost=1, valid=0, near=0, dist_avg=0 after 4th stb. Next result=1000 -> lost=0, valid stays 0 until 8 accepts.
5. rst pulsed on the edge between capture and accumulate -> no sample_stb; sum and dist_avg remain 0.
6. trig held high 1000 cycles with result changing -> exactly one sample; rises on consecutive 2-cycle periods -> one stb per rise, none lost.
